// File: rtl/magic_pkg.sv
// Shared definitions for the MAGIC NOR/NOT-mapped arithmetic blocks.
package magic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Gate budget of one full-subtractor bit cell as mapped onto crossbar ops.
  localparam int FS_NOR_GATES = 10;
  localparam int FS_NOT_GATES = 3;

endpackage

// File: rtl/magic_full_subtractor_bit.sv
// One-bit full subtractor (d = a - b - bin) expressed purely as NOR/NOT gates
// so that every gate corresponds to a single MAGIC crossbar operation.
module magic_full_subtractor_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic n1, n2, n3, xnor_ab;
  logic m1, m2, m3;
  logic xnor_ab_n, bin_n, t_prop, bout_n;

  // a XNOR b; n2 is also the generate term ~a & b
  nor g_n1 (n1, a, b);
  nor g_n2 (n2, a, n1);
  nor g_n3 (n3, b, n1);
  nor g_n4 (xnor_ab, n2, n3);

  // d = XNOR(xnor_ab, bin) = a ^ b ^ bin
  nor g_m1 (m1, xnor_ab, bin);
  nor g_m2 (m2, xnor_ab, m1);
  nor g_m3 (m3, bin, m1);
  nor g_d  (d, m2, m3);

  // Propagate term xnor_ab & bin, then bout = generate | propagate
  not g_i1 (xnor_ab_n, xnor_ab);
  not g_i2 (bin_n, bin);
  nor g_t  (t_prop, xnor_ab_n, bin_n);
  nor g_bo (bout_n, n2, t_prop);
  not g_i3 (bout, bout_n);

endmodule

// File: rtl/magic_serial_subtractor.sv
// Bit-serial, LSB-first unsigned subtractor (diff = a - b) with valid/ready
// handshakes on operand and result sides; one bit-cell evaluation per clock.
module magic_serial_subtractor
  import magic_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             busy
);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q, b_q, diff_q;
  logic             br_q, borrow_q;
  logic             in_ready_q, out_valid_q, busy_q;
  logic             d_bit, bout_bit;

  magic_full_subtractor_bit u_fs (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (br_q),
    .d    (d_bit),
    .bout (bout_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      diff_q      <= '0;
      br_q        <= 1'b0;
      borrow_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= a;
            b_q        <= b;
            br_q       <= 1'b0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          // Result fills from the MSB side so bit 0 lands at diff[0] after WIDTH shifts
          diff_q <= {d_bit, diff_q[WIDTH-1:1]};
          a_q    <= a_q >> 1;
          b_q    <= b_q >> 1;
          br_q   <= bout_bit;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            borrow_q    <= bout_bit;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign busy      = busy_q;

endmodule
